// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 key schedule that streams round keys from round 10 down to round 0
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     begin a schedule (sampled in IDLE only)
//   key_in    cipher key, w0 in [127:96], sampled with start
//   busy      high while expanding or emitting
//   rk_valid  rk_out / rk_round / rk_last are valid
//   rk_ready  consumer accepts the current round key
//   rk_out    current round key, w0 in [127:96]
//   rk_round  round index of rk_out (10..0)
//   rk_last   high with the round-0 key
//   done      one-cycle pulse after the round-0 key is accepted
//
// Optional feature: define AES_KEY_CACHE_EN to remember the last fully expanded key so a
// repeated start with the same key_in skips forward expansion.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         done
);
    localparam logic [3:0]  NR   = 4'd10;
    localparam logic [79:0] RCON = 80'h01020408102040801b36;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i == 4'd0 || i > NR) ? 8'h00 : RCON[8 * (int'(NR) - int'(i)) +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

    state_t        state, state_nx;
    logic [127:0]  w, w_nx, fwd, inv, hit_rk;
    logic [3:0]    rnd, rnd_nx;
    logic          done_q, done_nx, start_ok, cache_hit;
    logic [31:0]   t, g, f0, f1, f2, f3;

    // start is ignored while done is still high so a back-to-back pulse cannot restart
    assign start_ok = start & ~done_q;

    // One shared set of four S-boxes: forward rounds feed w3, inverse rounds feed the
    // recovered previous w3 (w3 ^ w2). rnd doubles as the forward round counter.
    always_comb begin
        t   = (state == EMIT) ? (w[31:0] ^ w[63:32]) : w[31:0];
        g   = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon(rnd), 24'h0};
        f0  = w[127:96] ^ g;
        f1  = w[95:64] ^ f0;
        f2  = w[63:32] ^ f1;
        f3  = w[31:0] ^ f2;
        fwd = {f0, f1, f2, f3};
        inv = {f0, w[95:64] ^ w[127:96], w[63:32] ^ w[95:64], t};
    end

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key, cache_rk;
    logic         cache_vld;

    assign cache_hit = cache_vld && (key_in == cache_key);
    assign hit_rk    = cache_rk;

    // The key is captured when expansion starts but only marked valid once the
    // round-10 key exists, so an aborted expansion never produces a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_key <= '0;
            cache_rk  <= '0;
            cache_vld <= 1'b0;
        end else if (state == IDLE && start_ok && !cache_hit) begin
            cache_key <= key_in;
            cache_vld <= 1'b0;
        end else if (state == FWD && rnd > NR) begin
            cache_rk  <= w;
            cache_vld <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_rk    = '0;
`endif

    always_comb begin
        state_nx = state;
        w_nx     = w;
        rnd_nx   = rnd;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok && cache_hit) begin
                    state_nx = EMIT;
                    w_nx     = hit_rk;
                    rnd_nx   = NR;
                end else if (start_ok) begin
                    state_nx = FWD;
                    w_nx     = key_in;
                    rnd_nx   = 4'd1;
                end
            end
            // Rounds 1..10 are applied while rnd <= NR; the pass with rnd == NR+1 only hands over.
            FWD: begin
                if (rnd > NR) begin
                    state_nx = EMIT;
                    rnd_nx   = NR;
                end else begin
                    w_nx   = fwd;
                    rnd_nx = rnd + 4'd1;
                end
            end
            EMIT: begin
                if (rk_ready && rnd == 4'd0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (rk_ready) begin
                    w_nx   = inv;
                    rnd_nx = rnd - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            w      <= '0;
            rnd    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            w      <= w_nx;
            rnd    <= rnd_nx;
            done_q <= done_nx;
        end
    end

    assign busy     = (state != IDLE);
    assign rk_valid = (state == EMIT);
    assign rk_out   = w;
    assign rk_round = rnd;
    assign rk_last  = rk_valid && (rnd == 4'd0);
    assign done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: randomized self-checking bench for aes_inv_key_sched against a FIPS-197 key expansion model
module tb_aes_inv_key_sched;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, rk_last, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int errors = 0, checks = 0;
    logic [7:0]   sbt [0:255];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int MISS_LAT = 11;
`ifdef AES_KEY_CACHE_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 11;
`endif

    aes_inv_key_sched dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round), .rk_last(rk_last), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine transform
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, r, s;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s ^= r;
            end
            sbt[x] = s ^ 8'h63;
        end
    endtask

    task automatic gen_keys(input logic [127:0] key);
        logic [31:0] wd [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) wd[i] = key[127 - 32 * i -: 32];
            else begin
                tmp = wd[i-1];
                if (i % 4 == 0) begin
                    tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
                    rc = xt(rc);
                end
                wd[i] = wd[i-4] ^ tmp;
            end
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_valid"}, 128'(rk_valid), 128'd0);
        check({tag, "_out"}, rk_out, 128'd0);
        check({tag, "_round"}, 128'(rk_round), 128'd0);
        check({tag, "_last"}, 128'(rk_last), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
    endtask

    task automatic start_and_wait(input logic [127:0] key, input int exp_lat, output bit ok);
        int n = 0;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on_start", 128'(busy), 128'd1);
        while (!rk_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", 128'(n), 128'(exp_lat));
        if (key == FIPS_KEY) check("fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ok = rk_valid;
    endtask

    // mode 0: always ready, 1: random ready, 2: five stall cycles at round 7
    task automatic stream(input logic [127:0] key, input int mode, input bit inj);
        int idx = 10, hold = 0, guard = 0;
        bit rdy;
        while (idx >= 0 && guard < 300) begin
            check("rk_valid", 128'(rk_valid), 128'd1);
            check("rk_round", 128'(rk_round), 128'(idx));
            check("rk_out", rk_out, exp_rk[idx]);
            check("rk_last", 128'(rk_last), 128'(idx == 0));
            if (key == FIPS_KEY && idx == 9) check("fips_rk9", rk_out, 128'hac7766f319fadc2128d12941575c006e);
            if (mode == 2 && idx == 7 && hold < 5) begin
                rdy = 1'b0;
                hold++;
            end else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            rk_ready = rdy;
            start    = inj && idx == 5;
            key_in   = ~key;
            @(posedge clk);
            #1 guard++;
            if (rdy) idx--;
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        check("done_pulse", 128'(done), 128'd1);
        check("busy_end", 128'(busy), 128'd0);
        check("valid_end", 128'(rk_valid), 128'd0);
        start = inj;
        @(posedge clk);
        #1 start = 1'b0;
        check("done_clear", 128'(done), 128'd0);
        check("busy_idle", 128'(busy), 128'd0);
    endtask

    task automatic run(input logic [127:0] key, input int lat, input int mode, input bit inj);
        bit ok;
        gen_keys(key);
        start_and_wait(key, lat, ok);
        if (ok) stream(key, mode, inj);
    endtask

    initial begin
        logic [127:0] k;
        bit ok;
        build_sbox();
        #2 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b1;

        run(FIPS_KEY, MISS_LAT, 0, 1'b0);
        run(FIPS_KEY, HIT_LAT, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run(k, MISS_LAT, 1, i[0]);
        end

        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_zero("rst_fwd");
        @(negedge clk) rst = 1'b1;

        k = {$urandom, $urandom, $urandom, $urandom};
        gen_keys(k);
        start_and_wait(k, MISS_LAT, ok);
        rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_zero("rst_emit");
        rk_ready = 1'b0;
        @(negedge clk) rst = 1'b1;

        run(k, MISS_LAT, 0, 1'b0);
        run(k, HIT_LAT, 1, 1'b1);
        run(~k, MISS_LAT, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
